periph_rx_arbiter: RTL and testbench

Round-robin scheduler that shares the single USB-bound packet stream among all peripheral rx FIFOs (UART and siblings). Each peripheral's local rx FIFO holds payload only. This block selects one non-empty FIFO at a time, pops up to a burst of words, prepends the peripheral address in the MSBs, and writes full USB packets into the shared USB tx FIFO.

---
 rtl/lycan_globals.sv | 11 +
 rtl/periph_arb_pkg.sv | 16 +
 rtl/rr_picker.sv | 41 ++++
 rtl/periph_rx_arbiter.sv | 121 ++++++++++++
 tb/tb_periph_rx_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lycan_globals.sv
`default_nettype none
// ============================================================================
// Module      : lycan_globals (package)
// Description : System-wide widths for the USB-bound packet stream.
// Revision    : 1.0 - initial release
// ============================================================================
package lycan_globals;
    localparam int usb_packet_width     = 32;
    localparam int periph_address_width = 3;
endpackage
`default_nettype wire

// File: rtl/periph_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : periph_arb_pkg (package)
// Description : Shared state type and payload width for periph_rx_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package periph_arb_pkg;
    localparam int PAYLOAD_W = lycan_globals::usb_packet_width
                             - lycan_globals::periph_address_width;

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        XFER = 1'b1
    } arb_state_t;
endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin priority encoder; the first request
//               at or after rr_ptr (modulo NUM_REQ) wins.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker
    import periph_arb_pkg::*;
#(
    parameter int NUM_REQ = 8,
    parameter int IDX_W   = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               valid
);

    int w_idx;

    // Walk offsets from farthest to nearest so the nearest requester is the
    // last assignment and therefore wins.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        w_idx  = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_idx = int'(rr_ptr) + i;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (req[w_idx]) begin
                winner = w_idx[IDX_W-1:0];
                valid  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/periph_rx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : periph_rx_arbiter
// Description : Round-robin drain of peripheral rx FIFOs into the USB tx FIFO,
//               tagging each word with the source index. Macro
//               PERIPH_ARB_BURST_EN enables bursts of up to BURST_MAX words.
// Revision    : 1.0 - initial release
// ============================================================================
module periph_rx_arbiter
    import lycan_globals::*;
    import periph_arb_pkg::*;
#(
    parameter int NUM_PERIPHS = 8,
    parameter int BURST_MAX   = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_PERIPHS*PAYLOAD_W-1:0]     periph_data,
    input  logic [NUM_PERIPHS-1:0]               periph_empty,
    output logic [NUM_PERIPHS-1:0]               periph_rden,
    output logic [usb_packet_width-1:0]          usb_data,
    output logic                                 usb_wren,
    input  logic                                 usb_full,
    output logic [periph_address_width-1:0]      grant,
    output logic                                 idle
);

    localparam int                          AW         = periph_address_width;
    localparam logic [AW-1:0]               c_last_idx = AW'(NUM_PERIPHS - 1);

    arb_state_t      r_state;
    logic [AW-1:0]   r_rr_ptr;
    logic [AW-1:0]   r_grant;
    logic [AW-1:0]   w_winner;
    logic            w_valid;
    logic            w_grant_empty;
    logic            w_fire;
    logic            w_last;
    logic [AW-1:0]   w_rr_next;
    logic [PAYLOAD_W-1:0] w_payload [NUM_PERIPHS];

    generate
        for (genvar gi = 0; gi < NUM_PERIPHS; gi++) begin : g_unpack
            assign w_payload[gi] = periph_data[gi*PAYLOAD_W +: PAYLOAD_W];
        end
    endgenerate

    rr_picker #(
        .NUM_REQ (NUM_PERIPHS),
        .IDX_W   (AW)
    ) u_rr_picker (
        .req     (~periph_empty),
        .rr_ptr  (r_rr_ptr),
        .winner  (w_winner),
        .valid   (w_valid)
    );

    assign w_grant_empty = periph_empty[r_grant];
    assign w_fire        = (r_state == XFER) & ~w_grant_empty & ~usb_full;
    assign w_rr_next     = (r_grant == c_last_idx) ? '0 : r_grant + 1'b1;

`ifdef PERIPH_ARB_BURST_EN
    localparam logic [7:0] c_burst_last = 8'(BURST_MAX - 1);
    logic [7:0] r_burst_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_burst_cnt <= '0;
        end else if (r_state == ARB) begin
            r_burst_cnt <= '0;
        end else if (w_fire) begin
            r_burst_cnt <= r_burst_cnt + 8'd1;
        end
    end

    assign w_last = (r_burst_cnt == c_burst_last);
`else
    assign w_last = 1'b1;
`endif

    // usb_full holds everything in XFER; only an empty source or the last
    // fire of the burst hands the stream to the next peripheral.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ARB;
            r_rr_ptr <= '0;
            r_grant  <= '0;
        end else begin
            case (r_state)
                ARB: begin
                    if (w_valid) begin
                        r_grant <= w_winner;
                        r_state <= XFER;
                    end
                end
                XFER: begin
                    if (w_grant_empty || (w_fire && w_last)) begin
                        r_state  <= ARB;
                        r_rr_ptr <= w_rr_next;
                    end
                end
                default: r_state <= ARB;
            endcase
        end
    end

    always_comb begin
        periph_rden = '0;
        usb_wren    = w_fire;
        usb_data    = '0;
        if (w_fire) begin
            periph_rden[r_grant] = 1'b1;
            usb_data             = {r_grant, w_payload[r_grant]};
        end
    end

    assign grant = r_grant;
    assign idle  = (r_state == ARB) & (&periph_empty);

endmodule
`default_nettype wire

// File: tb/tb_periph_rx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_periph_rx_arbiter
// Description : Scoreboard bench for periph_rx_arbiter with modelled FWFT FIFOs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_periph_rx_arbiter;

    localparam int N  = 8;
    localparam int PW = 29;
`ifdef PERIPH_ARB_BURST_EN
    localparam int B = 4;
`else
    localparam int B = 1;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N*PW-1:0] periph_data;
    logic [N-1:0]    periph_empty;
    logic [N-1:0]    periph_rden;
    logic [31:0]     usb_data;
    logic            usb_wren;
    logic            usb_full = 1'b0;
    logic [2:0]      grant;
    logic            idle;

    logic [PW-1:0] mem [N][32];
    logic [4:0]    rd_ptr [N] = '{default: '0};
    logic [4:0]    wr_ptr [N] = '{default: '0};

    logic [31:0] exp_q [$];
    int          tb_rr = 0;
    bit          sb_en = 1'b0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    periph_rx_arbiter #(
        .NUM_PERIPHS (N),
        .BURST_MAX   (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .periph_data  (periph_data),
        .periph_empty (periph_empty),
        .periph_rden  (periph_rden),
        .usb_data     (usb_data),
        .usb_wren     (usb_wren),
        .usb_full     (usb_full),
        .grant        (grant),
        .idle         (idle)
    );

    always_comb begin
        for (int i = 0; i < N; i++) begin
            periph_data[i*PW +: PW] = mem[i][rd_ptr[i]];
            periph_empty[i]         = (rd_ptr[i] == wr_ptr[i]);
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (periph_rden[i]) rd_ptr[i] <= rd_ptr[i] + 5'd1;
        end
    end

    task automatic load(input int p, input int n);
        logic [31:0] r;
        for (int k = 0; k < n; k++) begin
            r = $urandom;
            mem[p][wr_ptr[p]] = r[PW-1:0];
            wr_ptr[p] = wr_ptr[p] + 5'd1;
        end
    endtask

    // Expected write order from the FIFO contents: nearest non-empty FIFO at
    // or after tb_rr, min(count, B) words, then the pointer moves past it.
    task automatic build_expected();
        int          cnt [N];
        int          ptr [N];
        int          found;
        int          j;
        int          n;
        logic [2:0]  gi;
        logic [4:0]  rp;
        for (int i = 0; i < N; i++) begin
            cnt[i] = int'(wr_ptr[i] - rd_ptr[i]);
            ptr[i] = int'(rd_ptr[i]);
        end
        forever begin
            found = -1;
            for (int k = 0; k < N; k++) begin
                j = (tb_rr + k) % N;
                if (found < 0 && cnt[j] > 0) found = j;
            end
            if (found < 0) break;
            n  = (cnt[found] < B) ? cnt[found] : B;
            gi = found[2:0];
            for (int m = 0; m < n; m++) begin
                rp = 5'(ptr[found]);
                exp_q.push_back({gi, mem[found][rp]});
                ptr[found] = (ptr[found] + 1) % 32;
            end
            cnt[found] = cnt[found] - n;
            tb_rr = (found == N - 1) ? 0 : found + 1;
        end
    endtask

    // One clock; on the falling edge, retire any USB write into the scoreboard.
    task automatic cycle();
        logic [31:0] e;
        @(negedge clk);
        if (sb_en) begin
            if (usb_wren) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write got=%h expected=none", usb_data);
                end else begin
                    e = exp_q.pop_front();
                    if (usb_data !== e) begin
                        failures++;
                        $display("FAIL usb_data got=%h expected=%h", usb_data, e);
                    end
                end
            end else begin
                checks++;
                if (usb_data !== 32'h0) begin
                    failures++;
                    $display("FAIL usb_data_quiet got=%h expected=0", usb_data);
                end
            end
            if (periph_rden != '0) begin
                checks++;
                if ((periph_rden & periph_empty) != '0 || !$onehot(periph_rden) ||
                    periph_rden !== (8'd1 << grant) || usb_wren !== 1'b1) begin
                    failures++;
                    $display("FAIL rden_legal got rden=%b empty=%b grant=%0d wren=%b expected one-hot rden on non-empty grant",
                             periph_rden, periph_empty, grant, usb_wren);
                end
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        int stable = 0;
        for (int c = 0; c < 600 && stable < 2; c++) begin
            cycle();
            if (idle) stable++;
            else stable = 0;
        end
        checks++;
        if (stable < 2) begin
            failures++;
            $display("FAIL %s_idle_timeout got idle=%b expected idle=1", tag, idle);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_missing_words got remaining=%0d expected 0", tag, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        int wr_seen = 0;
        rst = 1'b1;
        cycle();
        checks++;
        if (periph_rden !== '0 || usb_wren !== 1'b0 || usb_data !== '0 || grant !== 3'd0) begin
            failures++;
            $display("FAIL reset_outputs got rden=%b wren=%b data=%h grant=%0d expected all 0",
                     periph_rden, usb_wren, usb_data, grant);
        end
        checks++;
        if (idle !== 1'b1) begin
            failures++;
            $display("FAIL reset_idle got=%b expected=1", idle);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        load(1, 4);
        for (int c = 0; c < 20 && wr_seen < 2; c++) begin
            cycle();
            if (usb_wren) wr_seen++;
        end
        checks++;
        if (wr_seen < 2) begin
            failures++;
            $display("FAIL reset_second_word_timeout got writes=%0d expected 2", wr_seen);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (periph_rden !== '0 || usb_wren !== 1'b0 || grant !== 3'd0) begin
            failures++;
            $display("FAIL reset_midburst got rden=%b wren=%b grant=%0d expected 0/0/0",
                     periph_rden, usb_wren, grant);
        end
        for (int i = 0; i < N; i++) wr_ptr[i] = rd_ptr[i];
        #1;
        checks++;
        if (idle !== 1'b1) begin
            failures++;
            $display("FAIL reset_state_arb got idle=%b expected=1", idle);
        end
        @(posedge clk); #1;
        rst   = 1'b0;
        tb_rr = 0;
        exp_q.delete();
        sb_en = 1'b1;
        load(7, 1);
        load(0, 1);
        build_expected();
        wait_idle("reset_rr_ptr");
    endtask

    task automatic test_fairness();
        @(posedge clk); #1;
        load(0, 10);
        load(3, 10);
        load(7, 10);
        build_expected();
        wait_idle("fairness");
    endtask

    task automatic test_single();
        int pat [64];
        int plen = 0;
        int rem  = 6;
        int n;
        while (rem > 0) begin
            pat[plen++] = 0;
            n = (rem < B) ? rem : B;
            for (int k = 0; k < n; k++) pat[plen++] = 1;
            rem -= n;
        end
        @(posedge clk); #1;
        load(2, 6);
        build_expected();
        for (int c = 0; c < plen + 2; c++) begin
            cycle();
            checks++;
            if (usb_wren !== ((c < plen) ? pat[c] != 0 : 1'b0)) begin
                failures++;
                $display("FAIL single_wren_c%0d got=%b expected=%b", c, usb_wren,
                         (c < plen) ? pat[c] != 0 : 1'b0);
            end
            if (usb_wren) begin
                checks++;
                if (usb_data[31:29] !== 3'd2) begin
                    failures++;
                    $display("FAIL single_addr got=%0d expected=2", usb_data[31:29]);
                end
            end
        end
        wait_idle("single");
    endtask

    task automatic test_backpressure();
        @(posedge clk); #1;
        load(5, 4);
        build_expected();
        cycle();
        cycle();
        @(posedge clk); #1;
        usb_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            checks++;
            if (usb_wren !== 1'b0 || periph_rden !== '0 || grant !== 3'd5) begin
                failures++;
                $display("FAIL backpressure_hold_%0d got wren=%b rden=%b grant=%0d expected 0/0/5",
                         k, usb_wren, periph_rden, grant);
            end
        end
        @(posedge clk); #1;
        usb_full = 1'b0;
        wait_idle("backpressure");
    endtask

    task automatic test_early_empty();
        int idle_at = (B > 1) ? 3 : 2;
        @(posedge clk); #1;
        load(4, 1);
        build_expected();
        for (int c = 0; c < 5; c++) begin
            cycle();
            checks++;
            if (idle !== (c >= idle_at)) begin
                failures++;
                $display("FAIL early_empty_idle_c%0d got=%b expected=%b", c, idle, c >= idle_at);
            end
        end
        wait_idle("early_empty");
        @(posedge clk); #1;
        load(3, 1);
        load(4, 1);
        load(5, 1);
        build_expected();
        wait_idle("early_empty_rr");
    endtask

    task automatic test_alternate();
        @(posedge clk); #1;
        load(1, 3);
        load(2, 3);
        build_expected();
        wait_idle("alternate");
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_single();
        test_backpressure();
        test_early_empty();
        test_alternate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
